// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [TAG_W-1:0]  tag_r;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   opb;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub, div_rem;
    logic [2*XLEN-1:0] next_prod;

    logic [2*XLEN-1:0] mul_val;
    logic [XLEN-1:0]   quo, rem, mul_res, div_res, fix_res;

    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state != S_IDLE);
    assign done_o  = (state == S_DONE) && !kill_i;
    assign accept  = valid_i && ready_o && !kill_i;

    // Operand decode at accept time: signedness, magnitudes and the
    // divide corner cases that bypass the iterative datapath.
    always_comb begin
        a_signed    = (funct3_i != F_MULHU) && (funct3_i != F_DIVU) && (funct3_i != F_REMU);
        b_signed    = a_signed && (funct3_i != F_MULHSU);
        a_neg       = a_signed && a_i[XLEN-1];
        b_neg       = b_signed && b_i[XLEN-1];
        a_mag       = a_neg ? -a_i : a_i;
        b_mag       = b_neg ? -b_i : b_i;
        div_zero    = funct3_i[2] && (b_i == '0);
        div_ovf     = funct3_i[2] && !funct3_i[0] && (a_i == SMIN) && (b_i == ONES);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = funct3_i[1] ? a_i : ONES;
        else if (!funct3_i[1])
            special_res = SMIN;
    end

    // One radix-2 step. Multiply keeps {partial, multiplier} in prod and
    // shifts right; divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : '0);
        div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_sub   = div_shift[XLEN-1:0] - opb;
        div_rem   = div_ge ? div_sub : div_shift[XLEN-1:0];
        next_prod = op[2] ? {div_rem, prod[XLEN-2:0], div_ge}
                          : {mul_sum, prod[XLEN-1:1]};
    end

    always_comb begin
        mul_val = neg_q ? -prod : prod;
        mul_res = (op == F_MUL) ? mul_val[XLEN-1:0] : mul_val[2*XLEN-1:XLEN];
        quo     = prod[XLEN-1:0];
        rem     = prod[2*XLEN-1:XLEN];
        if (op[1])
            div_res = neg_r ? -rem : rem;
        else
            div_res = neg_q ? -quo : quo;
        fix_res = op[2] ? div_res : mul_res;
    end

    // Control FSM and datapath registers; kill returns to IDLE without
    // touching the visible result/tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op       <= '0;
            tag_r    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            prod     <= '0;
            opb      <= '0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (kill_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op    <= funct3_i;
                        tag_r <= tag_i;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        if (special) begin
                            result_o <= special_res;
                            tag_o    <= tag_i;
                            state    <= S_DONE;
                        end else begin
                            prod  <= {{XLEN{1'b0}}, funct3_i[2] ? a_mag : b_mag};
                            opb   <= funct3_i[2] ? b_mag : a_mag;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prod <= next_prod;
                    if (cnt == LAST)
                        state <= S_FIX;
                    else
                        cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    result_o <= fix_res;
                    tag_o    <= tag_r;
                    state    <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, kill/reset sequences
// and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        valid32, valid16, kill32, kill16;
    logic [2:0]  funct3;
    logic [31:0] a_in, b_in;
    logic [4:0]  tag_in;

    logic        ready32, busy32, done32;
    logic [31:0] result32;
    logic [4:0]  tag32;
    logic        ready16, busy16, done16;
    logic [15:0] result16;
    logic [4:0]  tag16;

    int total;
    int passed;

    typedef struct {
        bit          sel16;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .valid_i(valid32), .ready_o(ready32),
        .funct3_i(funct3), .a_i(a_in), .b_i(b_in), .tag_i(tag_in),
        .kill_i(kill32), .busy_o(busy32), .done_o(done32),
        .result_o(result32), .tag_o(tag32)
    );

    muldiv_unit #(.XLEN(16), .TAG_W(5)) dut16 (
        .clk(clk), .reset(reset), .valid_i(valid16), .ready_o(ready16),
        .funct3_i(funct3), .a_i(a_in[15:0]), .b_i(b_in[15:0]), .tag_i(tag_in),
        .kill_i(kill16), .busy_o(busy16), .done_o(done16),
        .result_o(result16), .tag_o(tag16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RISC-V M semantics computed with plain 64-bit arithmetic.
    function automatic logic [31:0] model(input int xl, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, p, r;
        longint      sa, sb, smin;
        mask = (64'd1 << xl) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        sa   = longint'(ua << (64 - xl)) >>> (64 - xl);
        sb   = longint'(ub << (64 - xl)) >>> (64 - xl);
        smin = -(longint'(1) << (xl - 1));
        r    = 64'd0;
        case (f)
            3'd0: begin p = 64'(sa * sb);           r = p; end
            3'd1: begin p = 64'(sa * sb);           r = p >> xl; end
            3'd2: begin p = 64'(sa * longint'(ub)); r = p >> xl; end
            3'd3: begin p = ua * ub;                r = p >> xl; end
            3'd4: r = (ub == 0) ? mask : (sa == smin && sb == -1) ? ua : 64'(sa / sb);
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? ua : (sa == smin && sb == -1) ? 64'd0 : 64'(sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int model_lat(input int xl, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub;
        bit          special;
        mask    = (64'd1 << xl) - 64'd1;
        ua      = {32'b0, a} & mask;
        ub      = {32'b0, b} & mask;
        special = f[2] && ((ub == 0) ||
                  (!f[0] && ua == (64'd1 << (xl - 1)) && ub == mask));
        return special ? 1 : xl + 2;
    endfunction

    function automatic logic [31:0] pick_operand(input int xl);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = (xl == 16) ? 32'h0000_8000 : 32'h8000_0000;
            3: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue one operation and watch it to completion, recording done-cycle
    // offset from the accept edge, the returned result/tag and handshake shape.
    task automatic applyStimulus(input bit sel16, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag, output int lat,
                                 output logic [31:0] res, output logic [4:0] tg,
                                 output bit ready_low, output bit pulse_ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(sel16 ? ready16 : ready32) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        funct3 = f3;
        a_in   = a;
        b_in   = b;
        tag_in = tag;
        if (sel16) valid16 = 1'b1;
        else       valid32 = 1'b1;
        @(posedge clk);
        #1;
        valid32 = 1'b0;
        valid16 = 1'b0;
        a_in    = $urandom;
        b_in    = $urandom;
        funct3  = 3'($urandom);
        lat = 0; res = '0; tg = '0; ready_low = 1'b1; pulse_ok = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (sel16 ? ready16 : ready32) ready_low = 1'b0;
            if (sel16 ? done16 : done32) begin
                lat = c;
                res = sel16 ? {16'b0, result16} : result32;
                tg  = sel16 ? tag16 : tag32;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            pulse_ok = sel16 ? (!done16 && ready16) : (!done32 && ready32);
        end
    endtask

    task automatic run_check(input string name, input bit sel16, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                             input logic [31:0] exp, input int exp_lat);
        int          lat;
        logic [31:0] res;
        logic [4:0]  tg;
        bit          rl, po;
        applyStimulus(sel16, f3, a, b, tag, lat, res, tg, rl, po);
        checkOutput({name, " result"}, 64'(res), 64'(exp));
        checkOutput({name, " tag"}, 64'(tg), 64'(tag));
        checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, " ready low while busy"}, 64'(rl), 64'd1);
        checkOutput({name, " one-cycle done"}, 64'(po), 64'd1);
    endtask

    initial begin
        logic [31:0] prev_res;
        logic [4:0]  prev_tag;
        bit          saw_done;
        logic [2:0]  f;
        logic [31:0] ra, rb;
        logic [4:0]  rt;
        int          xl;

        total = 0; passed = 0;
        reset = 1'b1;
        valid32 = 0; valid16 = 0; kill32 = 0; kill16 = 0;
        funct3 = '0; a_in = '0; b_in = '0; tag_in = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset ready", 64'(ready32), 64'd1);
        checkOutput("reset busy", 64'(busy32), 64'd0);
        checkOutput("reset done", 64'(done32), 64'd0);
        checkOutput("reset result", 64'(result32), 64'd0);
        checkOutput("reset tag", 64'(tag32), 64'd0);
        checkOutput("reset ready16", 64'(ready16), 64'd1);

        vecs.push_back(vec_t'{1'b0, 3'b000, 32'h7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34});
        vecs.push_back(vec_t'{1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34});
        vecs.push_back(vec_t'{1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34});
        vecs.push_back(vec_t'{1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 34});
        vecs.push_back(vec_t'{1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 34});
        vecs.push_back(vec_t'{1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 34});
        vecs.push_back(vec_t'{1'b0, 3'b101, 32'd100,       32'd7,         5'd7, 32'd14,        34});
        vecs.push_back(vec_t'{1'b0, 3'b111, 32'd100,       32'd7,         5'd8, 32'd2,         34});
        vecs.push_back(vec_t'{1'b0, 3'b101, 32'd5,         32'd0,         5'd9, 32'hFFFF_FFFF, 1});
        vecs.push_back(vec_t'{1'b0, 3'b111, 32'd5,         32'd0,         5'd10, 32'd5,        1});
        vecs.push_back(vec_t'{1'b0, 3'b100, 32'h1234,      32'd0,         5'd11, 32'hFFFF_FFFF, 1});
        vecs.push_back(vec_t'{1'b0, 3'b110, 32'hFFFF_FF00, 32'd0,         5'd12, 32'hFFFF_FF00, 1});
        vecs.push_back(vec_t'{1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1});
        vecs.push_back(vec_t'{1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,        1});
        vecs.push_back(vec_t'{1'b1, 3'b011, 32'hFFFF,      32'hFFFF,      5'd15, 32'hFFFE,     18});

        for (int i = 0; i < vecs.size(); i++)
            run_check($sformatf("vec%0d", i), vecs[i].sel16, vecs[i].f3, vecs[i].a,
                      vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat);

        // Kill during CALC: no done, unit idle next cycle, outputs untouched.
        @(negedge clk);
        prev_res = result32;
        prev_tag = tag32;
        funct3 = 3'b100; a_in = 32'd1000; b_in = 32'd3; tag_in = 5'd21; valid32 = 1'b1;
        @(posedge clk);
        #1 valid32 = 1'b0;
        saw_done = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done32) saw_done = 1'b1;
        end
        @(negedge clk);
        kill32 = 1'b1;
        if (done32) saw_done = 1'b1;
        @(posedge clk);
        #1 kill32 = 1'b0;
        @(negedge clk);
        checkOutput("kill ready next cycle", 64'(ready32), 64'd1);
        checkOutput("kill result held", 64'(result32), 64'(prev_res));
        checkOutput("kill tag held", 64'(tag32), 64'(prev_tag));
        repeat (40) begin
            @(negedge clk);
            if (done32) saw_done = 1'b1;
        end
        checkOutput("kill no done", 64'(saw_done), 64'd0);

        // Kill in IDLE must block an otherwise valid request.
        funct3 = 3'b000; a_in = 32'd1; b_in = 32'd1; valid32 = 1'b1; kill32 = 1'b1;
        @(posedge clk);
        #1 begin valid32 = 1'b0; kill32 = 1'b0; end
        @(negedge clk);
        checkOutput("kill idle blocks accept", 64'(busy32), 64'd0);

        run_check("mul after kill", 1'b0, 3'b000, 32'd3, 32'd4, 5'd22, 32'd12, 34);

        // Reset in the middle of a 16-bit CALC.
        funct3 = 3'b011; a_in = 32'h1234; b_in = 32'h5678; tag_in = 5'd23; valid16 = 1'b1;
        @(posedge clk);
        #1 valid16 = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("xlen16 busy before reset", 64'(busy16), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("mid reset result", 64'(result16), 64'd0);
        checkOutput("mid reset tag", 64'(tag16), 64'd0);
        checkOutput("mid reset busy", 64'(busy16), 64'd0);
        checkOutput("mid reset ready", 64'(ready16), 64'd1);
        saw_done = done16;
        repeat (30) begin
            @(negedge clk);
            if (done16) saw_done = 1'b1;
        end
        checkOutput("mid reset no done", 64'(saw_done), 64'd0);

        for (int i = 0; i < 80; i++) begin
            xl = (i < 60) ? 32 : 16;
            f  = 3'($urandom);
            ra = pick_operand(xl);
            rb = pick_operand(xl);
            rt = 5'($urandom);
            run_check($sformatf("rand%0d f%0d a=%0h b=%0h", i, f, ra, rb), xl == 16, f, ra, rb, rt,
                      model(xl, f, ra, rb), model_lat(xl, f, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
